// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply front end: op encoding, in-flight tag, sign mapping.
// Pure declarations; no state.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       hi;
  } mul_tag_t;

  // Returns {rs1 signed, rs2 signed}.
  function automatic logic [1:0] mul_sign(input mul_op_t op);
    logic [1:0] s;
    s = 2'b00;
    case (op)
      MULH:    s = 2'b11;
      MULHSU:  s = 2'b10;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic mul_is_hi(input mul_op_t op);
    return op != MUL;
  endfunction

endpackage

// File: rtl/mul_tag_fifo.sv
// Small tag FIFO tracking {rd, hi} for ops inside the multiplier; zero-latency head read.
// Push is dropped only when full with no simultaneous pop; clear beats push and pop.
module mul_tag_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  mul_tag_t                     push_tag,
  input  logic                         pop,
  output mul_tag_t                     head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mul_tag_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/mul_frontend.sv
// Issue/writeback shell for the RV32M multiplier; one registered writeback slot after the product.
// Slot stall (wb_ready low while full) backpressures the multiplier, which drops in_ready the same cycle.
module mul_frontend
  import mul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  output logic        m_flush,
  output logic        m_in_valid,
  input  logic        m_in_ready,
  output logic [1:0]  m_in_sign,
  output logic [31:0] m_in_a,
  output logic [31:0] m_in_b,
  input  logic        m_out_valid,
  output logic        m_out_ready,
  input  logic [63:0] m_out_prod,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  mul_op_t          op;
  mul_tag_t         tag_in, tag_head;
  logic             tag_push, tag_pop, tag_full, tag_empty;
  logic [CNT_W-1:0] tag_count;

  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;

  assign op        = mul_op_t'(in_op);
  assign m_flush   = flush;
  assign m_in_sign = mul_sign(op);
  assign m_in_a    = in_rs1;
  assign m_in_b    = in_rs2;

  assign m_in_valid  = in_valid & ~tag_full & ~flush;
  assign in_ready    = m_in_ready & ~tag_full & ~flush;
  // Flush forces ready so the multiplier drains its held product.
  assign m_out_ready = ~wb_valid_q | wb_ready | flush;

  assign tag_in   = '{rd: in_rd, hi: mul_is_hi(op)};
  assign tag_push = m_in_valid & m_in_ready;
  assign tag_pop  = m_out_valid & m_out_ready & ~tag_empty & ~flush;

  mul_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tags (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .push     (tag_push),
    .push_tag (tag_in),
    .pop      (tag_pop),
    .head     (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (tag_pop) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = tag_head.rd;
      wb_data_d  = tag_head.hi ? m_out_prod[63:32] : m_out_prod[31:0];
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

  // A product with no tag behind it means the multiplier broke its handshake.
  a_no_orphan_product: assert property (@(posedge clock) disable iff (!reset)
    m_out_valid |-> !tag_empty);

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    tag_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_mul_frontend.sv
// Bench for mul_frontend: single-stage multiplier stand-in, table vectors, random streams
// scored against an arithmetic reference, plus flush and async-reset sequences.
module tb_mul_frontend;

  logic        clock, reset, flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        m_flush, m_in_valid, m_in_ready;
  logic [1:0]  m_in_sign;
  logic [31:0] m_in_a, m_in_b;
  logic        m_out_valid, m_out_ready;
  logic [63:0] m_out_prod;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_tot = 0;
  int n_bad = 0;
  int n_wb  = 0;

  mul_frontend #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .m_flush(m_flush), .m_in_valid(m_in_valid), .m_in_ready(m_in_ready),
    .m_in_sign(m_in_sign), .m_in_a(m_in_a), .m_in_b(m_in_b),
    .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_prod(m_out_prod),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier stand-in: holds one product, result visible the cycle after acceptance.
  logic        fx_valid;
  logic [63:0] fx_prod;

  function automatic logic [63:0] fx_mul(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y;
    x = s[1] ? {{32{a[31]}}, a} : {32'd0, a};
    y = s[0] ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fx_valid <= 1'b0;
      fx_prod  <= '0;
    end else if (m_flush) begin
      fx_valid <= 1'b0;
    end else if (m_in_valid && m_in_ready) begin
      fx_valid <= 1'b1;
      fx_prod  <= fx_mul(m_in_sign, m_in_a, m_in_b);
    end else if (m_out_ready) begin
      fx_valid <= 1'b0;
    end
  end

  assign m_in_ready  = ~fx_valid | m_out_ready;
  assign m_out_valid = fx_valid;
  assign m_out_prod  = fx_prod;

  // Reference: RV32M semantics straight from the op name.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    longint          sa, sb;
    logic [63:0]     p;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * longint'(ub);
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbexp_t;

  wbexp_t      exp_q[$];
  bit          prev_stall;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", wb_valid, 1);
        chk("hold_rd", wb_rd, prev_rd);
        chk("hold_data", wb_data, prev_data);
      end
      if (wb_valid && wb_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          n_bad++;
          $display("FAIL sb_extra: result rd=%0d data=%0h with nothing expected", wb_rd, wb_data);
        end else begin
          wbexp_t e;
          e = exp_q.pop_front();
          chk("sb_rd", wb_rd, e.rd);
          chk("sb_data", wb_data, e.data);
        end
        n_wb++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{rd: in_rd, data: ref_mul(in_op, in_rs1, in_rs2)});
      prev_stall = wb_valid && !wb_ready && !flush;
      prev_rd    = wb_rd;
      prev_data  = wb_data;
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_rd    = rd;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tot++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, want 1");
    end
  endtask

  logic [1:0]  rop [8];
  logic [31:0] ra  [8];
  logic [31:0] rb  [8];
  logic [4:0]  rrd [8];

  task automatic run_stream(input bit toggle);
    int idx, k, start;
    bit fire;
    idx   = 0;
    k     = 0;
    start = n_wb;
    while ((idx < 8 || n_wb - start < 8) && k < 200) begin
      wb_ready = toggle ? ~wb_ready : 1'b1;
      if (idx < 8) begin
        in_valid = 1'b1;
        in_op    = rop[idx];
        in_rs1   = ra[idx];
        in_rs2   = rb[idx];
        in_rd    = rrd[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      if (!toggle) begin
        if (k >= 2 && k <= 9) chk("b2b_wb_valid", wb_valid, 1);
        if (k < 8) chk("b2b_in_ready", in_ready, 1);
      end else if (wb_valid && !wb_ready && fx_valid) begin
        chk("stall_in_ready", in_ready, 0);
      end
      fire = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (fire) idx++;
      k++;
    end
    in_valid = 1'b0;
    chk("stream_count", n_wb - start, 8);
    chk("stream_left", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000};
    tbl[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF};
    tbl[3] = '{2'b00, 32'h00010001, 32'h00010001, 5'd8,  32'h00020001};
    tbl[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001};
    tbl[5] = '{2'b01, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000};
    tbl[6] = '{2'b10, 32'h80000000, 32'h00000002, 5'd11, 32'hFFFFFFFF};
    tbl[7] = '{2'b11, 32'h80000000, 32'h00000002, 5'd12, 32'h00000001};
    tbl[8] = '{2'b00, 32'h00000003, 32'h00000004, 5'd31, 32'h0000000C};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; wb_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_m_out_ready", m_out_ready, 1);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
      @(negedge clock);
      chk("vec_early_valid", wb_valid, 0);
      @(negedge clock);
      chk("vec_valid", wb_valid, 1);
      chk("vec_rd", wb_rd, tbl[i].rd);
      chk("vec_data", wb_data, tbl[i].exp);
      @(posedge clock); #1;
    end

    for (int i = 0; i < 8; i++) begin
      rop[i] = 2'($urandom_range(0, 3));
      ra[i]  = $urandom;
      rb[i]  = $urandom;
      rrd[i] = 5'($urandom_range(1, 31));
    end
    ra[0] = 32'h80000000;
    rb[1] = 32'hFFFFFFFF;
    run_stream(1'b0);
    wb_ready = 1'b1;
    run_stream(1'b1);
    wb_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Flush with the slot stalled full and a second op held in the multiplier.
    wb_ready = 1'b0;
    do_op(2'b00, 32'd100, 32'd100, 5'd1);
    do_op(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd2);
    @(negedge clock);
    chk("fl_pre_wb_valid", wb_valid, 1);
    chk("fl_pre_mult_busy", fx_valid, 1);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("fl_in_ready", in_ready, 0);
    chk("fl_m_flush", m_flush, 1);
    chk("fl_m_out_ready", m_out_ready, 1);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("fl_wb_valid", wb_valid, 0);
    chk("fl_fifo_count", dut.u_tags.count, 0);
    chk("fl_mult_drained", fx_valid, 0);
    @(posedge clock); #1;
    wb_ready = 1'b1;
    do_op(2'b00, 32'd3, 32'd4, 5'd7);
    @(negedge clock);
    chk("fl_next_early", wb_valid, 0);
    @(negedge clock);
    chk("fl_next_valid", wb_valid, 1);
    chk("fl_next_rd", wb_rd, 7);
    chk("fl_next_data", wb_data, 12);
    @(posedge clock); #1;

    // Asynchronous reset while a result sits in the slot.
    wb_ready = 1'b0;
    do_op(2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd3);
    @(negedge clock);
    @(negedge clock);
    chk("ar_pre_valid", wb_valid, 1);
    chk("ar_pre_data", wb_data, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_wb_valid", wb_valid, 0);
    chk("ar_wb_rd", wb_rd, 0);
    chk("ar_wb_data", wb_data, 0);
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b1;
    wb_ready = 1'b1;
    @(posedge clock); #1;
    do_op(2'b00, 32'd7, 32'd6, 5'd9);
    @(negedge clock);
    @(negedge clock);
    chk("ar_next_valid", wb_valid, 1);
    chk("ar_next_rd", wb_rd, 9);
    chk("ar_next_data", wb_data, 42);
    @(posedge clock); #1;
    repeat (2) @(negedge clock);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
